// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_pkg
//  Purpose  : Shared CPU control codes for the RV32M multiply/divide unit.
//             Holds the 6-bit ALUControl M-extension codes, the MDU state
//             encodings and small helpers that classify an operation code.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

    // ALUControl codes. ALU_ADD is kept so that callers can issue a non-M op.
    localparam logic [5:0] ALU_ADD    = 6'h00;
    localparam logic [5:0] ALU_MUL    = 6'h20;
    localparam logic [5:0] ALU_MULH   = 6'h21;
    localparam logic [5:0] ALU_MULHSU = 6'h22;
    localparam logic [5:0] ALU_MULHU  = 6'h23;
    localparam logic [5:0] ALU_DIV    = 6'h24;
    localparam logic [5:0] ALU_DIVU   = 6'h25;
    localparam logic [5:0] ALU_REM    = 6'h26;
    localparam logic [5:0] ALU_REMU   = 6'h27;

    // MDU state encodings
    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_CALC = 2'd1;
    localparam logic [1:0] MDU_FIN  = 2'd2;

    function automatic logic is_m_op(input logic [5:0] op);
        return (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                           ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
    endfunction

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU});
    endfunction

    // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM
    function automatic logic is_a_signed(input logic [5:0] op);
        return (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    endfunction

    // rs2 is treated as signed for MUL/MULH/DIV/REM
    function automatic logic is_b_signed(input logic [5:0] op);
        return (op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_signfix
//  Purpose  : Combinational sign handling for the multiply/divide unit.
//             Front side: split operands into sign flags and magnitudes.
//             Back side : negate the unsigned product/quotient/remainder as
//                         required and select the architectural result.
//  Ports    : i_op/i_src_a/i_src_b        -> o_a_mag/o_b_mag/o_a_neg/o_b_neg
//             i_res_op/i_res_a_neg/i_res_b_neg/i_product/i_quotient/
//             i_remainder                 -> o_result
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_signfix
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]         i_op,
    input  logic [WIDTH-1:0]   i_src_a,
    input  logic [WIDTH-1:0]   i_src_b,
    output logic [WIDTH-1:0]   o_a_mag,
    output logic [WIDTH-1:0]   o_b_mag,
    output logic               o_a_neg,
    output logic               o_b_neg,
    input  logic [5:0]         i_res_op,
    input  logic               i_res_a_neg,
    input  logic               i_res_b_neg,
    input  logic [2*WIDTH-1:0] i_product,
    input  logic [WIDTH-1:0]   i_quotient,
    input  logic [WIDTH-1:0]   i_remainder,
    output logic [WIDTH-1:0]   o_result
);

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    always_comb begin
        o_a_neg = is_a_signed(i_op) & i_src_a[WIDTH-1];
        o_b_neg = is_b_signed(i_op) & i_src_b[WIDTH-1];
        o_a_mag = o_a_neg ? (-i_src_a) : i_src_a;
        o_b_mag = o_b_neg ? (-i_src_b) : i_src_b;
    end

    always_comb begin
        // Full double-width negation before a half is picked, so MULH sees
        // the borrow out of the low half.
        w_prod_fix = (i_res_a_neg ^ i_res_b_neg) ? (-i_product) : i_product;
        w_quot_fix = (i_res_a_neg ^ i_res_b_neg) ? (-i_quotient) : i_quotient;
        // Remainder follows the dividend sign
        w_rem_fix  = i_res_a_neg ? (-i_remainder) : i_remainder;

        o_result = '0;
        case (i_res_op)
            ALU_MUL:                          o_result = w_prod_fix[WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  o_result = w_prod_fix[2*WIDTH-1:WIDTH];
            ALU_DIV, ALU_DIVU:                o_result = w_quot_fix;
            ALU_REM, ALU_REMU:                o_result = w_rem_fix;
            default:                          o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle RV32M execution unit. Radix-2 shift-add multiply
//             and restoring divide, one iteration per clock. Busy stalls the
//             core until the single-cycle Done pulse.
//  Ports    : clk, rst_n (async, active-low), Start, ALUControl[5:0],
//             SrcA/SrcB[WIDTH-1:0] in; Result[WIDTH-1:0], Busy, Done out.
//  Options  : MULDIV_FAST_MUL_EN - when defined, multiply ops use a single
//             combinational WIDTHxWIDTH product and finish one cycle after
//             Start. Divides are unaffected.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    localparam int c_CNT_W = $clog2(WIDTH);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [5:0]         r_op;
    logic               r_a_neg;
    logic               r_b_neg;
    logic [WIDTH-1:0]   r_mcand;     // multiplicand, or divisor, magnitude
    logic [WIDTH-1:0]   r_hi;        // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;        // multiplier->product low / dividend->quotient
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_special;
    logic [WIDTH-1:0]   r_spec_res;
    logic [WIDTH-1:0]   r_result;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_spec_res;
    logic               w_fast;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_calc_res;
    logic [WIDTH-1:0]   w_fin_result;

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .i_op        (ALUControl),
        .i_src_a     (SrcA),
        .i_src_b     (SrcB),
        .o_a_mag     (w_a_mag),
        .o_b_mag     (w_b_mag),
        .o_a_neg     (w_a_neg),
        .o_b_neg     (w_b_neg),
        .i_res_op    (r_op),
        .i_res_a_neg (r_a_neg),
        .i_res_b_neg (r_b_neg),
        .i_product   ({r_hi, r_lo}),
        .i_quotient  (r_lo),
        .i_remainder (r_hi),
        .o_result    (w_calc_res)
    );

    // ---------------------------------------------------------------- accept
    always_comb begin
        w_accept   = (r_state == MDU_IDLE) && Start && is_m_op(ALUControl);
        w_is_mul   = is_mul_op(ALUControl);
        w_div_zero = (SrcB == '0);
        w_ovf      = (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1) &&
                     ((ALUControl == ALU_DIV) || (ALUControl == ALU_REM));
        w_special  = !w_is_mul && (w_div_zero || w_ovf);
        if (w_div_zero)
            w_spec_res = ((ALUControl == ALU_DIV) || (ALUControl == ALU_DIVU)) ? '1 : SrcA;
        else
            w_spec_res = (ALUControl == ALU_DIV) ? SrcA : '0;
`ifdef MULDIV_FAST_MUL_EN
        w_fast = w_is_mul;
`else
        w_fast = 1'b0;
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

    // ------------------------------------------------------------- iteration
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_mcand};
    end

    assign w_fin_result = r_special ? r_spec_res : w_calc_res;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= MDU_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MDU_IDLE: if (w_accept) w_state_nxt = (w_special || w_fast) ? MDU_FIN : MDU_CALC;
            MDU_CALC: if (r_cnt == '0) w_state_nxt = MDU_FIN;
            MDU_FIN:  w_state_nxt = MDU_IDLE;
            default:  w_state_nxt = MDU_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_mcand    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (w_accept) begin
                        r_op       <= ALUControl;
                        r_a_neg    <= w_a_neg;
                        r_b_neg    <= w_b_neg;
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                        r_cnt      <= c_CNT_W'(WIDTH - 1);
                        r_hi       <= '0;
                        if (w_is_mul) begin
                            r_mcand <= w_a_mag;
                            r_lo    <= w_b_mag;
                        end else begin
                            r_mcand <= w_b_mag;
                            r_lo    <= w_a_mag;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        if (w_is_mul) begin
                            r_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_fast_prod[WIDTH-1:0];
                        end
`endif
                    end
                end
                MDU_CALC: begin
                    if (is_mul_op(r_op)) begin
                        // Add-then-shift: the multiplier drains out of r_lo
                        // as product bits shift in from the top.
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end else if (!w_div_diff[WIDTH]) begin
                        r_hi <= w_div_diff[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_hi <= w_div_shift[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - c_CNT_W'(1);
                end
                MDU_FIN: r_result <= w_fin_result;
                default: ;
            endcase
        end
    end

    // Result is live during the Done cycle and held afterwards
    assign Busy   = (r_state != MDU_IDLE);
    assign Done   = (r_state == MDU_FIN);
    assign Result = Done ? w_fin_result : r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit. A behavioural model built
//             from 64-bit arithmetic predicts Busy/Done/Result every cycle;
//             directed cases pin literal results and latencies, then random
//             operations exercise the full op set.
//  Options  : MULDIV_FAST_MUL_EN changes the expected multiply latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [5:0]  ALUControl = ALU_ADD;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [31:0] Result;
    logic        Busy;
    logic        Done;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start      (Start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Result     (Result),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ reference
    function automatic logic is_m(input logic [5:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic [31:0] ref_result(input logic [5:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            ALU_MULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if ((op >= ALU_DIV) && (b == 0)) return 1;
        if (((op == ALU_DIV) || (op == ALU_REM)) &&
            (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (op <= ALU_MULHU) return 1;
`endif
        return 33;
    endfunction

    // Cycle model: m_left counts remaining busy cycles after acceptance
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_held = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_pend = '0;
            m_held = '0;
        end else if (m_left == 0) begin
            if (Start && is_m(ALUControl)) begin
                m_left = ref_latency(ALUControl, SrcA, SrcB);
                m_pend = ref_result(ALUControl, SrcA, SrcB);
            end
        end else begin
            if (m_left == 1) m_held = m_pend;
            m_left = m_left - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    logic chk_en = 1'b1;
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   32'(Busy), 32'(m_left > 0));
            check("done",   32'(Done), 32'(m_left == 1));
            check("result", Result, (m_left == 1) ? m_pend : m_held);
        end
    end

    // -------------------------------------------------------------- drivers
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic lit_en, input logic [31:0] lit, input int inject);
        int cyc;
        int exp_lat;
        exp_lat = ref_latency(op, a, b);
        @(posedge clk); #1;
        Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        cyc = 1;
        while (Done !== 1'b1 && cyc < 40) begin
            if (cyc == inject) begin
                Start = 1'b1; SrcA = $urandom; SrcB = $urandom | 32'h1;
            end
            @(posedge clk); #1;
            Start = 1'b0;
            cyc = cyc + 1;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        if (lit_en) check("result_lit", Result, lit);
    endtask

    task automatic issue_non_m(input logic [5:0] op);
        @(posedge clk); #1;
        Start = 1'b1; ALUControl = op; SrcA = $urandom; SrcB = $urandom;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("nonm_busy", 32'(Busy), 32'h0);
        check("nonm_done", 32'(Done), 32'h0);
    endtask

    logic [5:0] op_tab [9] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_ADD};

    initial begin
        // model pinned to hand-computed values
        check("model_mulhu",  ref_result(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_mulhsu", ref_result(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model_rem",    ref_result(ALU_REM,    32'hFFFF_FFF9, 32'h2),         32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(Busy), 32'h0);
        check("reset_done",   32'(Done), 32'h0);
        check("reset_result", Result,    32'h0);
        rst_n = 1'b1;

        run_op(ALU_MUL,    32'd7,          32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 0);
        run_op(ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 0);
        run_op(ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 0);
        run_op(ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 0);
        run_op(ALU_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 0);
        run_op(ALU_DIV,    32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD, 0);
        run_op(ALU_REM,    32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF, 0);
        run_op(ALU_DIVU,   32'd100,        32'd7,         1'b1, 32'd14,        0);
        run_op(ALU_REMU,   32'd100,        32'd7,         1'b1, 32'd2,         0);
        run_op(ALU_DIV,    32'd5,          32'd0,         1'b1, 32'hFFFF_FFFF, 0);
        run_op(ALU_REMU,   32'd5,          32'd0,         1'b1, 32'd5,         0);
        run_op(ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0);
        run_op(ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h0,         0);
        issue_non_m(ALU_ADD);
        // Start re-asserted mid-divide with new operands must be ignored
        run_op(ALU_DIV,    32'd1000,       32'd7,         1'b1, 32'd142,       10);

        // Reset mid-multiply aborts asynchronously
        @(posedge clk); #1;
        Start = 1'b1; ALUControl = ALU_MUL; SrcA = 32'h0001_2345; SrcB = 32'h777;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(Busy), 32'h0);
        check("abort_done",   32'(Done), 32'h0);
        check("abort_result", Result,    32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(ALU_MUL, 32'd3, 32'd4, 1'b1, 32'd12, 0);

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            logic [5:0]  op;
            logic [31:0] a, b;
            int          k;
            op = op_tab[$urandom_range(0, 8)];
            a  = $urandom;
            b  = $urandom;
            k  = $urandom_range(0, 9);
            if (k == 0) b = 32'h0;
            else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (k == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            else if (k == 3) b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            if (op == ALU_ADD) issue_non_m(op);
            else run_op(op, a, b, 1'b0, 32'h0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
